// File: rtl/mem_port_ctrl.sv
// Purpose: bridges 32-bit word read/write requests onto a byte-wide external RAM port.
// Latency: read completes (DONE, ram_rdata valid) 6 cycles after request, write 5 cycles.
// Backpressure: rdy=0 freezes all state and masks ext_wr; new requests only accepted in IDLE.
module mem_port_ctrl #(
    parameter int ADDR_W = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              ram_re,
    input  logic [31:0]       ram_raddr,
    output logic [31:0]       ram_rdata,
    output logic              ram_rbusy,
    input  logic              ram_we,
    input  logic [31:0]       ram_waddr,
    input  logic [31:0]       ram_wdata,
    output logic              ram_wbusy,
    output logic [ADDR_W-1:0] ext_addr,
    output logic [7:0]        ext_dout,
    input  logic [7:0]        ext_din,
    output logic              ext_wr
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [2:0]        r_cnt;
    logic [2:0]        w_cnt_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [23:0]       r_rbuf;   // bytes 0..2 of the word being read
    logic [31:0]       r_rdata;  // last completed read word
    logic              w_start_wr;
    logic              w_start_rd;

    // Only the low ADDR_W bits of the request addresses reach the external port.
    if (ADDR_W < 32) begin : g_addr_unused
        logic w_unused;
        assign w_unused = ^{ram_raddr[31:ADDR_W], ram_waddr[31:ADDR_W]};
    end

    // Next-state / counter logic; writes take priority over reads in IDLE.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_start_wr  = 1'b0;
        w_start_rd  = 1'b0;
        case (r_state)
            IDLE: begin
                if (ram_we) begin
                    w_state_nxt = WR;
                    w_cnt_nxt   = 3'd0;
                    w_start_wr  = 1'b1;
                end else if (ram_re) begin
                    w_state_nxt = RD;
                    w_cnt_nxt   = 3'd0;
                    w_start_rd  = 1'b1;
                end
            end
            RD: begin
                if (r_cnt == 3'd4) begin
                    w_state_nxt = DONE;
                    w_cnt_nxt   = 3'd0;
                end else begin
                    w_cnt_nxt = r_cnt + 3'd1;
                end
            end
            WR: begin
                if (r_cnt == 3'd3) begin
                    w_state_nxt = DONE;
                    w_cnt_nxt   = 3'd0;
                end else begin
                    w_cnt_nxt = r_cnt + 3'd1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = 3'd0;
            end
        endcase
    end

    // State, counter, latched request and read assembly; rst beats rdy, rdy=0 holds everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= 3'd0;
            r_addr  <= '0;
            r_wdata <= 32'd0;
            r_rbuf  <= 24'd0;
            r_rdata <= 32'd0;
        end else if (rdy) begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_start_wr) begin
                r_addr  <= ram_waddr[ADDR_W-1:0];
                r_wdata <= ram_wdata;
            end else if (w_start_rd) begin
                r_addr <= ram_raddr[ADDR_W-1:0];
            end
            // ext_din carries the byte addressed one cycle earlier; the word is
            // committed only when its last byte lands so a partial read never shows.
            if (r_state == RD) begin
                case (r_cnt)
                    3'd1:    r_rbuf[7:0]   <= ext_din;
                    3'd2:    r_rbuf[15:8]  <= ext_din;
                    3'd3:    r_rbuf[23:16] <= ext_din;
                    3'd4:    r_rdata       <= {ext_din, r_rbuf};
                    default: r_rbuf        <= r_rbuf;
                endcase
            end
        end
    end

    // Write byte lane selected by the byte counter (little-endian).
    always_comb begin
        ext_dout = r_wdata[7:0];
        case (r_cnt[1:0])
            2'd1:    ext_dout = r_wdata[15:8];
            2'd2:    ext_dout = r_wdata[23:16];
            2'd3:    ext_dout = r_wdata[31:24];
            default: ext_dout = r_wdata[7:0];
        endcase
    end

    // Address increments wrap naturally in ADDR_W bits.
    assign ext_addr  = r_addr + {{(ADDR_W-3){1'b0}}, r_cnt};
    // Masked by rst so an aborted write drives no further strobes in its last cycle.
    assign ext_wr    = (r_state == WR) && rdy && !rst;
    assign ram_rdata = r_rdata;
    assign ram_rbusy = !rst && ((r_state == RD) || ((r_state == IDLE) && ram_re && !ram_we));
    assign ram_wbusy = !rst && ((r_state == WR) || ((r_state == IDLE) && ram_we));

endmodule
